// File: rtl/wiener_block_to_raster_axis.sv
// Block-order to raster-order converter: buffers one block row (BLOCK_SIZE lines) of Wiener
// output and replays it as an AXI4-Stream master. Optional error flags: WIENER_RASTER_ERR_EN.
module wiener_block_to_raster_axis #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 8,
    parameter int MAX_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           frame_width,
    input  logic [15:0]           frame_height,
    input  logic                  start_of_frame,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done,
`ifdef WIENER_RASTER_ERR_EN
    output logic [2:0]            err_flags,
`endif
    output logic                  busy
);

    localparam int DEPTH = BLOCK_SIZE * MAX_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(BLOCK_SIZE);
    localparam int EW    = DATA_WIDTH + 3;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    state_t                state_q;
    logic [15:0]           width_q;
    logic [15:0]           height_q;
    logic [15:0]           block_row_q;
    logic                  in_ready_q;
    logic                  busy_q;
    logic                  frame_done_q;

    // Write side: column/row inside the block, block index, and running address bases
    logic [BW-1:0]         c_q;
    logic [BW-1:0]         r_q;
    logic [15:0]           b_q;
    logic [AW-1:0]         row_base_q;
    logic [AW-1:0]         blk_base_q;

    // Read side: linear address plus raster column/line trackers for the flags
    logic [AW-1:0]         ra_q;
    logic [15:0]           dcol_q;
    logic [BW-1:0]         drow_q;
    logic                  issue_done_q;
    logic                  rd_vld_q;
    logic [2:0]            rd_flags_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Two-entry output skid; entry 0 is the head that drives the AXI outputs
    logic [EW-1:0]         ent0_q, ent0_d;
    logic [EW-1:0]         ent1_q, ent1_d;
    logic [1:0]            cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic                  c_max, r_max, b_last, fill_done;
    logic                  pop, issue;
    logic [2:0]            occ_after;
    logic                  col_last, rd_end;
    logic                  row_done, frame_last;
    logic [EW-1:0]         push_word;

`ifdef WIENER_RASTER_ERR_EN
    logic [2:0]            err_q;
    logic                  size_ok;

    assign size_ok = (frame_width != 16'd0) && (frame_height != 16'd0)
                  && (frame_width[BW-1:0] == '0) && (frame_height[BW-1:0] == '0)
                  && (frame_width <= 16'(MAX_WIDTH));
    assign err_flags = err_q;
`endif

    assign wr_en      = in_valid && in_ready_q;
    assign wr_addr    = row_base_q + {{(AW-BW){1'b0}}, c_q};
    assign c_max      = &c_q;
    assign r_max      = &r_q;
    assign b_last     = ((b_q + 16'd1) << BW) == width_q;
    assign fill_done  = wr_en && c_max && r_max && b_last;

    assign pop        = (cnt_q != 2'd0) && m_axis_tready;
    // Issue only when the word could still land in the skid after everything in flight
    assign occ_after  = {1'b0, cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
    assign issue      = (state_q == S_DRAIN) && !issue_done_q && (occ_after <= 3'd1);
    assign col_last   = dcol_q == (width_q - 16'd1);
    assign rd_end     = col_last && (&drow_q);

    assign push_word  = {rd_flags_q, rd_data_q};
    assign row_done   = pop && ent0_q[EW-1];
    assign frame_last = ((block_row_q + 16'd1) << BW) == height_q;

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign m_axis_tvalid = cnt_q != 2'd0;
    assign m_axis_tdata  = ent0_q[DATA_WIDTH-1:0];
    assign m_axis_tlast  = ent0_q[DATA_WIDTH];
    assign m_axis_tuser  = ent0_q[DATA_WIDTH+1];

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({rd_vld_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) ent0_d = push_word;
                else               ent1_d = push_word;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = push_word;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_word;
                end
            end
            default: ;
        endcase
    end

    // Line buffer: plain synchronous-read array so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= in_data;
        if (issue) rd_data_q <= mem_q[ra_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            block_row_q  <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            c_q          <= '0;
            r_q          <= '0;
            b_q          <= '0;
            row_base_q   <= '0;
            blk_base_q   <= '0;
            ra_q         <= '0;
            dcol_q       <= '0;
            drow_q       <= '0;
            issue_done_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_flags_q   <= '0;
            ent0_q       <= '0;
            ent1_q       <= '0;
            cnt_q        <= '0;
`ifdef WIENER_RASTER_ERR_EN
            err_q        <= '0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            cnt_q        <= cnt_d;
            rd_vld_q     <= issue;

            if (issue) begin
                rd_flags_q <= {rd_end, (ra_q == '0) && (block_row_q == 16'd0), col_last};
                ra_q       <= ra_q + AW'(1);
                if (col_last) begin
                    dcol_q <= '0;
                    drow_q <= drow_q + BW'(1);
                    if (&drow_q) issue_done_q <= 1'b1;
                end else begin
                    dcol_q <= dcol_q + 16'd1;
                end
            end

            if (wr_en) begin
                c_q <= c_q + BW'(1);
                if (c_max) begin
                    r_q <= r_q + BW'(1);
                    if (r_max) begin
                        b_q        <= b_q + 16'd1;
                        blk_base_q <= blk_base_q + AW'(BLOCK_SIZE);
                        row_base_q <= blk_base_q + AW'(BLOCK_SIZE);
                    end else begin
                        row_base_q <= row_base_q + width_q[AW-1:0];
                    end
                end
            end

            case (state_q)
                S_FILL: begin
                    if (fill_done) begin
                        state_q      <= S_DRAIN;
                        in_ready_q   <= 1'b0;
                        ra_q         <= '0;
                        dcol_q       <= '0;
                        drow_q       <= '0;
                        issue_done_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (row_done) begin
                        c_q        <= '0;
                        r_q        <= '0;
                        b_q        <= '0;
                        row_base_q <= '0;
                        blk_base_q <= '0;
                        if (frame_last) begin
                            state_q      <= S_IDLE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            block_row_q <= block_row_q + 16'd1;
                            state_q     <= S_FILL;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

`ifdef WIENER_RASTER_ERR_EN
            if (in_valid && busy_q && !in_ready_q) err_q[0] <= 1'b1;
`endif

            // A new frame overrides everything above, including a drain in progress
            if (start_of_frame) begin
                width_q      <= frame_width;
                height_q     <= frame_height;
                block_row_q  <= '0;
                c_q          <= '0;
                r_q          <= '0;
                b_q          <= '0;
                row_base_q   <= '0;
                blk_base_q   <= '0;
                ra_q         <= '0;
                dcol_q       <= '0;
                drow_q       <= '0;
                issue_done_q <= 1'b0;
                rd_vld_q     <= 1'b0;
                cnt_q        <= '0;
                frame_done_q <= 1'b0;
                state_q      <= S_FILL;
                in_ready_q   <= 1'b1;
                busy_q       <= 1'b1;
`ifdef WIENER_RASTER_ERR_EN
                err_q <= {busy_q, !size_ok, 1'b0};
                if (!size_ok) begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
`endif
            end
        end
    end

endmodule
